// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the load/store unit.
//   Word-addressed RAM of 2**ADDR_W x 32 bits. Loads get byte-lane selection
//   and sign/zero extension; sub-word stores are merged by read-modify-write.
//   Misaligned, out-of-range and illegal-op accesses are rejected with rsp_err.
// Optional feature macro: DMEM_CONSOLE_EN (SB to 0xFFFF_FFF0 drives a console byte).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_we, req_op       store flag, funct3 access type
//   req_addr, req_wdata  byte address, right-aligned store data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata, rsp_err   extended load data (0 for stores/errors), reject flag
//   cons_valid/cons_data console byte strobe (DMEM_CONSOLE_EN only)
module dmem_responder #(
   parameter int unsigned ADDR_W = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
`ifdef DMEM_CONSOLE_EN
   ,
   output logic        cons_valid,
   output logic [7:0]  cons_data
`endif
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [31:0] CONS_ADDR = 32'hFFFF_FFF0;

   typedef enum logic [2:0] {IDLE, RD, MRG, WR, RSP} state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_req_ready;
   logic                r_rsp_valid;
   logic [31:0]         r_rsp_rdata;
   logic                r_rsp_err;
   logic [31:0]         w_rdata_nxt;
   logic                w_err_nxt;

   // latched request
   logic                r_we;
   logic [2:0]          r_op;
   logic [1:0]          r_lane;
   logic [ADDR_W-1:0]   r_idx;
   logic [31:0]         r_wdata;
   logic                r_cons;

   logic [31:0]         r_mem [DEPTH];
   logic [31:0]         r_ram_q;

   logic                w_accept;
   logic [ADDR_W-1:0]   w_req_idx;
   logic [ADDR_W-1:0]   w_rd_idx;
   logic                w_cons_hit;
   logic                w_range_err;
   logic                w_illegal;
   logic                w_misal;
   logic                w_req_err;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [31:0]         w_load;
   logic [31:0]         w_merged;

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

   assign w_accept  = req_valid && r_req_ready;
   assign w_req_idx = req_addr[ADDR_W+1:2];

`ifdef DMEM_CONSOLE_EN
   assign w_cons_hit = req_we && (req_op == 3'd0) && (req_addr == CONS_ADDR);
`else
   assign w_cons_hit = 1'b0;
`endif

   // Accept-time checks; the console byte address is exempt from the range check
   assign w_range_err = |req_addr[31:ADDR_W+2];
   assign w_illegal   = req_we ? (req_op >= 3'd3)
                               : ((req_op == 3'd3) || (req_op == 3'd6) || (req_op == 3'd7));
   assign w_misal     = ((req_op[1:0] == 2'd1) && req_addr[0]) ||
                        ((req_op[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
   assign w_req_err   = w_illegal || w_misal || (w_range_err && !w_cons_hit);

   // In IDLE the RAM is addressed straight from the request so data is ready in RD
   assign w_rd_idx = (r_state == IDLE) ? w_req_idx : r_idx;

   // RAM: synchronous read every cycle, write only in WR and never under reset
   always_ff @(posedge clk) begin
      r_ram_q <= r_mem[w_rd_idx];
      if (!rst && (r_state == WR) && !r_cons) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

   // Request latch; in MRG the store word is replaced by the merged word
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_we    <= req_we;
         r_op    <= req_op;
         r_lane  <= req_addr[1:0];
         r_idx   <= w_req_idx;
         r_wdata <= req_wdata;
         r_cons  <= w_cons_hit;
      end else if (r_state == MRG) begin
         r_wdata <= w_merged;
      end
   end

   // Load lane select and extension
   assign w_byte = 8'(r_ram_q >> {r_lane, 3'b000});
   assign w_half = 16'(r_ram_q >> {r_lane[1], 4'b0000});

   always_comb begin
      w_load = 32'd0;
      case (r_op)
         3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
         3'd1:    w_load = {{16{w_half[15]}}, w_half};
         3'd2:    w_load = r_ram_q;
         3'd4:    w_load = {24'd0, w_byte};
         3'd5:    w_load = {16'd0, w_half};
         default: w_load = 32'd0;
      endcase
   end

   // Sub-word store merge: only the addressed lanes of the old word change
   always_comb begin
      w_merged = r_ram_q;
      if (r_op[1:0] == 2'd0) begin
         case (r_lane)
            2'd0:    w_merged[7:0]   = r_wdata[7:0];
            2'd1:    w_merged[15:8]  = r_wdata[7:0];
            2'd2:    w_merged[23:16] = r_wdata[7:0];
            default: w_merged[31:24] = r_wdata[7:0];
         endcase
      end else if (r_lane[1]) begin
         w_merged[31:16] = r_wdata[15:0];
      end else begin
         w_merged[15:0] = r_wdata[15:0];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and next response payload
   always_comb begin
      w_state_nxt = r_state;
      w_rdata_nxt = r_rsp_rdata;
      w_err_nxt   = r_rsp_err;
      case (r_state)
         IDLE: begin
            w_rdata_nxt = 32'd0;
            w_err_nxt   = 1'b0;
            if (w_accept) begin
               if (w_req_err) begin
                  w_state_nxt = RSP;
                  w_err_nxt   = 1'b1;
               end else if (w_cons_hit || (req_we && (req_op == 3'd2))) begin
                  w_state_nxt = WR;
               end else begin
                  w_state_nxt = RD;
               end
            end
         end
         RD: begin
            if (r_we) begin
               w_state_nxt = MRG;
            end else begin
               w_state_nxt = RSP;
               w_rdata_nxt = w_load;
            end
         end
         MRG: w_state_nxt = WR;
         WR:  w_state_nxt = RSP;
         RSP: begin
            if (rsp_ready) begin
               w_state_nxt = IDLE;
               w_rdata_nxt = 32'd0;
               w_err_nxt   = 1'b0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Registered handshake and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_req_ready <= (w_state_nxt == IDLE);
         r_rsp_valid <= (w_state_nxt == RSP);
         r_rsp_rdata <= w_rdata_nxt;
         r_rsp_err   <= w_err_nxt;
      end
   end

`ifdef DMEM_CONSOLE_EN
   logic       r_cons_valid;
   logic [7:0] r_cons_data;

   assign cons_valid = r_cons_valid;
   assign cons_data  = r_cons_data;

   // One-cycle console strobe in the cycle after accept
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cons_valid <= 1'b0;
         r_cons_data  <= 8'd0;
      end else begin
         r_cons_valid <= w_accept && w_cons_hit;
         if (w_accept && w_cons_hit) begin
            r_cons_data <= req_wdata[7:0];
            $write("%c", req_wdata[7:0]);
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: each request pushes its expected response
// to a scoreboard queue; the response is popped and compared when rsp_valid rises.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
`ifdef DMEM_CONSOLE_EN
   logic        cons_valid;
   logic [7:0]  cons_data;
   int          cons_pulses = 0;
   logic [7:0]  cons_last   = 8'd0;
`endif

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(7)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
`ifdef DMEM_CONSOLE_EN
      ,
      .cons_valid(cons_valid),
      .cons_data (cons_data)
`endif
   );

`ifdef DMEM_CONSOLE_EN
   always @(negedge clk) begin
      if (cons_valid) begin
         cons_pulses++;
         cons_last = cons_data;
      end
   end
`endif

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request at a negedge, measure latency in cycles from accept,
   // optionally hold rsp_ready low for 'hold' cycles, then complete the handshake.
   task automatic xact(input string tag, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] erd, input logic eerr, input int elat,
                       input int hold);
      exp_t        e;
      exp_t        got;
      int          lat;
      bit          done;
      logic [31:0] rd0;
      logic        er0;
      e.rdata = erd;
      e.err   = eerr;
      e.lat   = elat;
      sb_q.push_back(e);
      rsp_ready = (hold == 0);
      req_valid = 1'b1;
      req_we    = we;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      lat = 0;
      while (!req_ready && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!req_ready) begin
         checks++;
         failures++;
         $error("FAIL %s_accept observed=no_ready expected=ready within 20 cycles", tag);
         req_valid = 1'b0;
         void'(sb_q.pop_front());
         return;
      end
      lat  = 0;
      done = 1'b0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 1) req_valid = 1'b0;
         if (rsp_valid) done = 1'b1;
      end
      got = sb_q.pop_front();
      if (!done) begin
         checks++;
         failures++;
         $error("FAIL %s_rsp observed=no_rsp_valid expected=rsp within 20 cycles", tag);
         rsp_ready = 1'b1;
         return;
      end
      check({tag, "_lat"},   32'(lat),       32'(got.lat));
      check({tag, "_rdata"}, rsp_rdata,      got.rdata);
      check({tag, "_err"},   32'(rsp_err),   32'(got.err));
      check({tag, "_rdy"},   32'(req_ready), 32'd0);
      rd0 = rsp_rdata;
      er0 = rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_vld"},   32'(rsp_valid), 32'd1);
         check({tag, "_hold_rdata"}, rsp_rdata,      rd0);
         check({tag, "_hold_err"},   32'(rsp_err),   32'(er0));
         check({tag, "_hold_rdy"},   32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check({tag, "_post_vld"}, 32'(rsp_valid), 32'd0);
      check({tag, "_post_rdy"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_op    = 3'd0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata,      32'd0);
      check("rst_rsp_err",   32'(rsp_err),   32'd0);
`ifdef DMEM_CONSOLE_EN
      check("rst_cons_valid", 32'(cons_valid), 32'd0);
      check("rst_cons_data",  32'(cons_data),  32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // Word store then load
      xact("sw10",  1'b1, 3'd2, 32'h10, 32'h8000_00FF, 32'd0,         1'b0, 2, 0);
      xact("lw10",  1'b0, 3'd2, 32'h10, 32'd0,         32'h8000_00FF, 1'b0, 2, 0);

      // Sub-word stores and extended loads
      xact("sb13",  1'b1, 3'd0, 32'h13, 32'h0000_00A5, 32'd0,         1'b0, 4, 0);
      xact("lb13",  1'b0, 3'd0, 32'h13, 32'd0,         32'hFFFF_FFA5, 1'b0, 2, 0);
      xact("lbu13", 1'b0, 3'd4, 32'h13, 32'd0,         32'h0000_00A5, 1'b0, 2, 0);
      xact("lw10b", 1'b0, 3'd2, 32'h10, 32'd0,         32'hA500_00FF, 1'b0, 2, 0);
      xact("lh12",  1'b0, 3'd1, 32'h12, 32'd0,         32'hFFFF_A500, 1'b0, 2, 0);
      xact("lhu12", 1'b0, 3'd5, 32'h12, 32'd0,         32'h0000_A500, 1'b0, 2, 0);
      xact("sh12",  1'b1, 3'd1, 32'h12, 32'hFFFF_1234, 32'd0,         1'b0, 4, 0);
      xact("lw10c", 1'b0, 3'd2, 32'h10, 32'd0,         32'h1234_00FF, 1'b0, 2, 0);
      xact("lb11",  1'b0, 3'd0, 32'h11, 32'd0,         32'd0,         1'b0, 2, 0);
      xact("lh10",  1'b0, 3'd1, 32'h10, 32'd0,         32'h0000_00FF, 1'b0, 2, 0);

      // Errors and range boundary
      xact("sh11",  1'b1, 3'd1, 32'h11,  32'h1234,      32'd0,         1'b1, 1, 0);
      xact("lw10d", 1'b0, 3'd2, 32'h10,  32'd0,         32'h1234_00FF, 1'b0, 2, 0);
      xact("lw200", 1'b0, 3'd2, 32'h200, 32'd0,         32'd0,         1'b1, 1, 0);
      xact("sw1fc", 1'b1, 3'd2, 32'h1FC, 32'hCAFE_F00D, 32'd0,         1'b0, 2, 0);
      xact("lw1fc", 1'b0, 3'd2, 32'h1FC, 32'd0,         32'hCAFE_F00D, 1'b0, 2, 0);
      xact("st_op3",1'b1, 3'd3, 32'h10,  32'hFFFF_FFFF, 32'd0,         1'b1, 1, 0);
      xact("lw12",  1'b0, 3'd2, 32'h12,  32'd0,         32'd0,         1'b1, 1, 0);
      xact("lw10e", 1'b0, 3'd2, 32'h10,  32'd0,         32'h1234_00FF, 1'b0, 2, 0);
      xact("sb10",  1'b1, 3'd0, 32'h10,  32'hFFFF_FF5A, 32'd0,         1'b0, 4, 0);
      xact("lw10f", 1'b0, 3'd2, 32'h10,  32'd0,         32'h1234_005A, 1'b0, 2, 0);

      // Illegal load op with response back-pressure
      xact("ld_op3",1'b0, 3'd3, 32'h10,  32'd0,         32'd0,         1'b1, 1, 5);

      // Reset during the WR cycle of a word store suppresses the write
      xact("sw20",  1'b1, 3'd2, 32'h20,  32'h1111_2222, 32'd0,         1'b0, 2, 0);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_op    = 3'd2;
      req_addr  = 32'h20;
      req_wdata = 32'hDEAD_BEEF;
      check("rstwr_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstwr_req_ready", 32'(req_ready), 32'd1);
      check("rstwr_rsp_valid", 32'(rsp_valid), 32'd0);
      xact("lw20",  1'b0, 3'd2, 32'h20,  32'd0,         32'h1111_2222, 1'b0, 2, 0);

      // Console byte address
      xact("sw1f0", 1'b1, 3'd2, 32'h1F0, 32'h0BAD_F00D, 32'd0,         1'b0, 2, 0);
`ifdef DMEM_CONSOLE_EN
      xact("cons",  1'b1, 3'd0, 32'hFFFF_FFF0, 32'h0000_0041, 32'd0,   1'b0, 2, 0);
      check("cons_pulses", 32'(cons_pulses), 32'd1);
      check("cons_data",   32'(cons_last),   32'h41);
`else
      xact("cons",  1'b1, 3'd0, 32'hFFFF_FFF0, 32'h0000_0041, 32'd0,   1'b1, 1, 0);
`endif
      xact("lw1f0", 1'b0, 3'd2, 32'h1F0, 32'd0,         32'h0BAD_F00D, 1'b0, 2, 0);

      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
